add_seq_ctrl: RTL

//  Multi-precision add/subtract sequencer built around one shared add_8bit instance.

---
 rtl/add_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams two NWORDS-byte operands through one
// shared 8-bit adder, LSB byte first, chaining the carry through a register.

module add_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module add_seq_ctrl #(
  parameter int unsigned NWORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NWORDS-1:0] op_a,
  input  logic [8*NWORDS-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NWORDS-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [NWORDS-1:0][7:0] a_q;
  logic [NWORDS-1:0][7:0] b_q;  // already inverted for subtraction
  logic [NWORDS-1:0][7:0] res_q;
  logic [IW-1:0]          idx_q;
  logic                   carry_q;

  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_s;
  logic       add_co;

  assign add_a  = a_q[idx_q];
  assign add_b  = b_q[idx_q];
  assign result = res_q;

  add_8bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            carry_q <= sub;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          res_q[idx_q] <= add_s;
          carry_q      <= add_co;
          if (idx_q == LastIdx) begin
            cout    <= add_co;
            ovf     <= (add_a[7] ~^ add_b[7]) & (add_s[7] ^ add_a[7]);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
